// File: rtl/hazard_pkg.sv
// Shared types and default latencies for the MIPS pipeline hazard unit.
package hazard_pkg;

    localparam int REG_AW_DEF     = 5;
    localparam int MUL_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF = 32;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // MEM-stage data is younger than WB data, so it takes priority.
    function automatic fwd_sel_e fwd_pick(input logic mem_hit, input logic wb_hit);
        fwd_sel_e sel;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle of pipeline register tags in, forward/stall controls out.
interface hazard_unit_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] rs_d;
    logic [REG_AW-1:0] rt_d;
    logic [REG_AW-1:0] rs_e;
    logic [REG_AW-1:0] rt_e;
    logic [REG_AW-1:0] write_reg_e;
    logic [REG_AW-1:0] write_reg_m;
    logic [REG_AW-1:0] write_reg_w;
    logic              reg_write_e;
    logic              reg_write_m;
    logic              reg_write_w;
    logic              mem_to_reg_e;
    logic              mem_to_reg_m;
    logic              branch_d;
    logic              md_op_d;
    logic              md_start_e;
    logic              md_is_div_e;

    logic [1:0]        forward_a_e;
    logic [1:0]        forward_b_e;
    logic              forward_a_d;
    logic              forward_b_d;
    logic              stall_f;
    logic              stall_d;
    logic              flush_e;
    logic              md_busy;

    modport master (
        output rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
               reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m,
               branch_d, md_op_d, md_start_e, md_is_div_e,
        input  forward_a_e, forward_b_e, forward_a_d, forward_b_d,
               stall_f, stall_d, flush_e, md_busy
    );

    modport slave (
        input  rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
               reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m,
               branch_d, md_op_d, md_start_e, md_is_div_e,
        output forward_a_e, forward_b_e, forward_a_d, forward_b_d,
               stall_f, stall_d, flush_e, md_busy
    );

endinterface

// File: rtl/hazard_unit_chk.sv
// Invariants of the hazard unit: no mult/div issue while busy, no 2'b11 select.
module hazard_unit_chk (
    input logic       clk,
    input logic       rst_n,
    input logic       md_start,
    input logic       md_busy,
    input logic [1:0] fwd_a,
    input logic [1:0] fwd_b
);

    a_no_issue_while_busy: assert property (
        @(posedge clk) disable iff (!rst_n) !(md_start && md_busy)
    );

    a_fwd_a_legal: assert property (
        @(posedge clk) disable iff (!rst_n) fwd_a != 2'b11
    );

    a_fwd_b_legal: assert property (
        @(posedge clk) disable iff (!rst_n) fwd_b != 2'b11
    );

endmodule

// File: rtl/md_busy_tracker.sv
// Occupancy tracker for the multi-cycle mult/div unit: busy for exactly
// MUL_CYCLES or DIV_CYCLES cycles starting the cycle after issue.
module md_busy_tracker
    import hazard_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    md_state_e        state_q;
    md_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // State and remaining-cycle counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; a start while busy is ignored since decode stalls it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    cnt_d   = is_div ? DIV_LOAD : MUL_LOAD;
                    state_d = MD_BUSY;
                end else begin
                    cnt_d   = CNT_ZERO;
                    state_d = MD_IDLE;
                end
            end
            MD_BUSY: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d   = cnt_q - CNT_ONE;
                    state_d = MD_BUSY;
                end else begin
                    cnt_d   = CNT_ZERO;
                    state_d = MD_IDLE;
                end
            end
            default: begin
                cnt_d   = CNT_ZERO;
                state_d = MD_IDLE;
            end
        endcase
    end

    assign busy = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_unit.sv
// Forwarding selects and stall/flush control for the 5-stage MIPS core,
// including mult/div occupancy tracking.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEF,
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input logic          clk,
    input logic          rst_n,
    hazard_unit_if.slave hz
);

    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

    fwd_sel_e fwd_a_e_s;
    fwd_sel_e fwd_b_e_s;
    logic     fwd_a_d_s;
    logic     fwd_b_d_s;
    logic     lw_stall_s;
    logic     br_stall_s;
    logic     md_stall_s;
    logic     md_busy_s;

    // A write to $0 is discarded by the register file, so it never matches.
    function automatic logic dest_hit(input logic en, input logic [REG_AW-1:0] wr,
                                      input logic [REG_AW-1:0] src);
        return en && (wr != REG_ZERO) && (wr == src);
    endfunction

    md_busy_tracker #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_busy_tracker (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (hz.md_start_e),
        .is_div (hz.md_is_div_e),
        .busy   (md_busy_s)
    );

    // Operand forwarding for EX muxes and the decode branch comparator.
    always_comb begin
        fwd_a_e_s = fwd_pick(dest_hit(hz.reg_write_m, hz.write_reg_m, hz.rs_e),
                             dest_hit(hz.reg_write_w, hz.write_reg_w, hz.rs_e));
        fwd_b_e_s = fwd_pick(dest_hit(hz.reg_write_m, hz.write_reg_m, hz.rt_e),
                             dest_hit(hz.reg_write_w, hz.write_reg_w, hz.rt_e));
        fwd_a_d_s = dest_hit(hz.reg_write_m, hz.write_reg_m, hz.rs_d);
        fwd_b_d_s = dest_hit(hz.reg_write_m, hz.write_reg_m, hz.rt_d);
    end

    // Stall sources; a branch also waits on a load still in MEM.
    always_comb begin
        lw_stall_s = hz.mem_to_reg_e &&
                     (dest_hit(hz.reg_write_e, hz.write_reg_e, hz.rs_d) ||
                      dest_hit(hz.reg_write_e, hz.write_reg_e, hz.rt_d));
        br_stall_s = hz.branch_d &&
                     (dest_hit(hz.reg_write_e,  hz.write_reg_e, hz.rs_d) ||
                      dest_hit(hz.reg_write_e,  hz.write_reg_e, hz.rt_d) ||
                      dest_hit(hz.mem_to_reg_m, hz.write_reg_m, hz.rs_d) ||
                      dest_hit(hz.mem_to_reg_m, hz.write_reg_m, hz.rt_d));
        md_stall_s = hz.md_op_d && (md_busy_s || hz.md_start_e);
    end

    assign hz.forward_a_e = fwd_a_e_s;
    assign hz.forward_b_e = fwd_b_e_s;
    assign hz.forward_a_d = fwd_a_d_s;
    assign hz.forward_b_d = fwd_b_d_s;
    assign hz.stall_f     = lw_stall_s | br_stall_s | md_stall_s;
    assign hz.stall_d     = lw_stall_s | br_stall_s | md_stall_s;
    assign hz.flush_e     = lw_stall_s | br_stall_s | md_stall_s;
    assign hz.md_busy     = md_busy_s;

    hazard_unit_chk u_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .md_start (hz.md_start_e),
        .md_busy  (md_busy_s),
        .fwd_a    (fwd_a_e_s),
        .fwd_b    (fwd_b_e_s)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: an abstract pipeline model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_hazard_unit;

    localparam int MUL_N = 4;
    localparam int DIV_N = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    bit   run_cmp = 1'b0;
    int   md_left = 0;

    always #5 clk = ~clk;

    hazard_unit_if #(.REG_AW(5)) hz ();

    hazard_unit #(
        .REG_AW     (5),
        .MUL_CYCLES (MUL_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    // Model: cycles of mult/div occupancy still to come.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)               md_left <= 0;
        else if (md_left > 0)     md_left <= md_left - 1;
        else if (hz.md_start_e)   md_left <= hz.md_is_div_e ? DIV_N : MUL_N;
    end

    function automatic logic [1:0] mdl_fwd(input int src);
        logic [1:0] r;
        r = 2'd0;
        if (src != 0 && hz.reg_write_w && int'(hz.write_reg_w) == src) r = 2'd1;
        if (src != 0 && hz.reg_write_m && int'(hz.write_reg_m) == src) r = 2'd2;
        return r;
    endfunction

    function automatic logic mdl_stall();
        int  srcs[2];
        logic s;
        srcs[0] = int'(hz.rs_d);
        srcs[1] = int'(hz.rt_d);
        s = hz.md_op_d && (md_left > 0 || hz.md_start_e);
        foreach (srcs[k]) begin
            if (srcs[k] != 0) begin
                if (hz.mem_to_reg_e && hz.reg_write_e && int'(hz.write_reg_e) == srcs[k]) s = 1'b1;
                if (hz.branch_d && hz.reg_write_e && int'(hz.write_reg_e) == srcs[k]) s = 1'b1;
                if (hz.branch_d && hz.mem_to_reg_m && int'(hz.write_reg_m) == srcs[k]) s = 1'b1;
            end
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (run_cmp) begin
            check("mdl_fa_e", hz.forward_a_e, mdl_fwd(int'(hz.rs_e)));
            check("mdl_fb_e", hz.forward_b_e, mdl_fwd(int'(hz.rt_e)));
            check("mdl_fa_d", {1'b0, hz.forward_a_d}, {1'b0, mdl_fwd(int'(hz.rs_d)) == 2'd2});
            check("mdl_fb_d", {1'b0, hz.forward_b_d}, {1'b0, mdl_fwd(int'(hz.rt_d)) == 2'd2});
            check("mdl_stall_f", {1'b0, hz.stall_f}, {1'b0, mdl_stall()});
            check("mdl_stall_d", {1'b0, hz.stall_d}, {1'b0, mdl_stall()});
            check("mdl_flush_e", {1'b0, hz.flush_e}, {1'b0, mdl_stall()});
            check("mdl_md_busy", {1'b0, hz.md_busy}, {1'b0, md_left > 0});
        end
    end

    task automatic clear_in();
        hz.rs_d = 5'd0;  hz.rt_d = 5'd0;  hz.rs_e = 5'd0;  hz.rt_e = 5'd0;
        hz.write_reg_e = 5'd0; hz.write_reg_m = 5'd0; hz.write_reg_w = 5'd0;
        hz.reg_write_e = 1'b0; hz.reg_write_m = 1'b0; hz.reg_write_w = 1'b0;
        hz.mem_to_reg_e = 1'b0; hz.mem_to_reg_m = 1'b0;
        hz.branch_d = 1'b0; hz.md_op_d = 1'b0;
        hz.md_start_e = 1'b0; hz.md_is_div_e = 1'b0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        clear_in();
    endtask

    task automatic expect_out(input string tag, input logic [1:0] fae, input logic [1:0] fbe,
                              input logic fad, input logic fbd, input logic st, input logic bz);
        check({tag, "_fa_e"}, hz.forward_a_e, fae);
        check({tag, "_fb_e"}, hz.forward_b_e, fbe);
        check({tag, "_fa_d"}, {1'b0, hz.forward_a_d}, {1'b0, fad});
        check({tag, "_fb_d"}, {1'b0, hz.forward_b_d}, {1'b0, fbd});
        check({tag, "_stall"}, {hz.stall_f & hz.stall_d & hz.flush_e,
                                hz.stall_f | hz.stall_d | hz.flush_e}, {st, st});
        check({tag, "_busy"}, {1'b0, hz.md_busy}, {1'b0, bz});
    endtask

    task automatic md_run(input string tag, input logic is_div, input int n);
        next();
        hz.md_start_e = 1'b1; hz.md_is_div_e = is_div; hz.md_op_d = 1'b1;
        @(negedge clk);
        expect_out({tag, "_issue"}, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= n + 1; i++) begin
            next();
            hz.md_op_d = 1'b1;
            @(negedge clk);
            expect_out($sformatf("%s_c%0d", tag, i), 2'd0, 2'd0, 1'b0, 1'b0, i <= n, i <= n);
        end
    endtask

    initial begin
        clear_in();
        @(posedge clk);
        run_cmp = 1'b1;
        @(negedge clk);
        expect_out("reset", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        next(); hz.rs_e = 5'd8; hz.reg_write_m = 1'b1; hz.write_reg_m = 5'd8;
        @(negedge clk); expect_out("t1", 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        next(); hz.rt_e = 5'd9; hz.reg_write_m = 1'b1; hz.write_reg_m = 5'd9;
        hz.reg_write_w = 1'b1; hz.write_reg_w = 5'd9;
        @(negedge clk); expect_out("t2_mem", 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        next(); hz.rt_e = 5'd9; hz.reg_write_w = 1'b1; hz.write_reg_w = 5'd9;
        @(negedge clk); expect_out("t2_wb", 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        next(); hz.reg_write_m = 1'b1; hz.reg_write_w = 1'b1; hz.rs_e = 5'd0; hz.rt_e = 5'd0;
        @(negedge clk); expect_out("t2_r0", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        next(); hz.mem_to_reg_e = 1'b1; hz.reg_write_e = 1'b1; hz.write_reg_e = 5'd10; hz.rs_d = 5'd10;
        @(negedge clk); expect_out("t3_stall", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        next(); hz.mem_to_reg_m = 1'b1; hz.reg_write_m = 1'b1; hz.write_reg_m = 5'd10; hz.rs_d = 5'd10;
        @(negedge clk); expect_out("t3_bubble", 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        next(); hz.reg_write_w = 1'b1; hz.write_reg_w = 5'd10; hz.rs_e = 5'd10;
        @(negedge clk); expect_out("t3_wb", 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        next(); hz.mem_to_reg_e = 1'b1; hz.reg_write_e = 1'b1; hz.write_reg_e = 5'd12; hz.rt_d = 5'd12;
        @(negedge clk); expect_out("t3_rt", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        next(); hz.mem_to_reg_e = 1'b1; hz.reg_write_e = 1'b1; hz.write_reg_e = 5'd0;
        @(negedge clk); expect_out("r0_lw", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        next(); hz.branch_d = 1'b1; hz.rs_d = 5'd11; hz.reg_write_e = 1'b1; hz.write_reg_e = 5'd11;
        @(negedge clk); expect_out("t4_stall", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        next(); hz.branch_d = 1'b1; hz.rs_d = 5'd11; hz.reg_write_m = 1'b1; hz.write_reg_m = 5'd11;
        @(negedge clk); expect_out("t4_fwd", 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        next(); hz.branch_d = 1'b1; hz.rt_d = 5'd13; hz.mem_to_reg_m = 1'b1;
        hz.reg_write_m = 1'b1; hz.write_reg_m = 5'd13;
        @(negedge clk); expect_out("t4_ldm", 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);

        md_run("t5_div", 1'b1, DIV_N);
        md_run("t5_mul", 1'b0, MUL_N);

        next(); hz.md_start_e = 1'b1; hz.md_is_div_e = 1'b1;
        for (int i = 1; i <= 10; i++) next();
        @(negedge clk); expect_out("t6_busy", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #2 rst_n = 1'b0;
        #1 check("t6_rst_busy", {1'b0, hz.md_busy}, 2'd0);
        @(negedge clk); #2 rst_n = 1'b1;
        next(); hz.md_op_d = 1'b1;
        @(negedge clk); expect_out("t6_idle", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        next();
        @(negedge clk);
        run_cmp = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, limit 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
